uart_rx_frame: RTL and testbench

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It runs entirely on the system clock, with an internal oversample-tick divider instead of a separate baud clock. It adds:

- configurable data width, oversampling and parity;
- input synchronisation and 3-sample majority voting;
- false-start rejection;
- parity and framing error reporting.

It sits between the board `uart_rx` pin and the CPU-side peripheral register block, which consumes a one-cycle `rx_valid` strobe.

---
 rtl/uart_rx_frame_if.sv | 30 +++
 rtl/uart_rx_frame.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial input and received-word bundle
// of the parametrised UART receiver.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (
    input  uart_rx,
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    output uart_rx,
    input  rx_data,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with majority
// vote, false-start rejection, parity and framing checks.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27
) (
  input  logic            clk_50m,
  input  logic            reset_b,
  uart_rx_frame_if.master bus
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [OW-1:0] P_LO  = OW'(M - 1);
  localparam logic [OW-1:0] P_MID = OW'(M);
  localparam logic [OW-1:0] P_DEC = OW'(M + 1);
  localparam logic [OW-1:0] P_END = OW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_END = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [TW-1:0]        r_tick_cnt;
  logic [OW-1:0]        r_os_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_perr;
  logic                 r_seen_hi;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr;

  logic          w_rxs;
  logic          w_tick;
  logic [OW-1:0] w_pos;
  logic          w_maj;
  logic          w_par;

  // r_os_cnt holds the position of the last tick; w_pos is this tick's
  assign w_rxs  = r_sync2;
  assign w_tick = (r_tick_cnt == T_END);
  assign w_pos  = (r_os_cnt == P_END) ? '0 : r_os_cnt + OW'(1);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_par  = ^r_shift;

  assign bus.rx_data       = r_data;
  assign bus.rx_valid      = r_valid;
  assign bus.rx_parity_err = r_perr_o;
  assign bus.rx_frame_err  = r_ferr;
  assign bus.rx_busy       = (r_state != S_IDLE);

  // two-flop synchroniser, idles high
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // free-running oversample tick divider
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // frame FSM with registered word, flags and strobe
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_perr    <= 1'b0;
      r_seen_hi <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        r_os_cnt <= w_pos;
        if (w_pos == P_LO)  r_s0 <= w_rxs;
        if (w_pos == P_MID) r_s1 <= w_rxs;
        unique case (r_state)
          S_IDLE: begin
            r_os_cnt <= '0;
            if (w_rxs) begin
              r_seen_hi <= 1'b1;
            end else if (r_seen_hi) begin
              r_state <= S_START;
            end
          end
          S_START: begin
            if (w_pos == P_DEC && w_maj) begin
              r_os_cnt <= '0;
              r_state  <= S_IDLE;
            end else if (w_pos == P_END) begin
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_pos == P_DEC) begin
              r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            end
            if (w_pos == P_END) begin
              if (r_bit_idx == B_END) begin
                r_state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + BW'(1);
              end
            end
          end
          S_PAR: begin
            if (w_pos == P_DEC) begin
              r_perr <= (PARITY == 1) ? ~(w_par ^ w_maj)
                                      : (w_par ^ w_maj);
            end
            if (w_pos == P_END) r_state <= S_STOP;
          end
          S_STOP: begin
            if (w_pos == P_DEC) begin
              r_data    <= r_shift;
              r_perr_o  <= r_perr;
              r_ferr    <= ~w_maj;
              r_valid   <= 1'b1;
              r_seen_hi <= w_maj;
              r_os_cnt  <= '0;
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and randomised frames on three
// receiver configurations, checked against a frame-level model.
module tb_uart_rx_frame;

  localparam int BITCLK = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   viol;

  frm_t qa[$];
  frm_t qb[$];
  frm_t qc[$];

  logic [9:0] prev_a;
  logic [9:0] prev_b;
  logic [8:0] prev_c;
  logic       pv_a;
  logic       pv_b;
  logic       pv_c;

  uart_rx_frame_if #(.DATA_BITS(8)) ifa ();
  uart_rx_frame_if #(.DATA_BITS(8)) ifb ();
  uart_rx_frame_if #(.DATA_BITS(7)) ifc ();

  uart_rx_frame #(
    .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16), .CLK_DIV(4)
  ) u_a (
    .clk_50m(clk), .reset_b(rst_n), .bus(ifa)
  );

  uart_rx_frame #(
    .DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16), .CLK_DIV(4)
  ) u_b (
    .clk_50m(clk), .reset_b(rst_n), .bus(ifb)
  );

  uart_rx_frame #(
    .DATA_BITS(7), .PARITY(0), .OVERSAMPLE(16), .CLK_DIV(4)
  ) u_c (
    .clk_50m(clk), .reset_b(rst_n), .bus(ifc)
  );

  initial clk = 1'b0;
  // free-running system clock
  always #5 clk = ~clk;

  // collect strobed frames; flag wide strobes and output drift
  always @(negedge clk) begin
    if (ifa.rx_valid)
      qa.push_back(frm_t'{ifa.rx_data, ifa.rx_parity_err,
                          ifa.rx_frame_err});
    if (ifb.rx_valid)
      qb.push_back(frm_t'{ifb.rx_data, ifb.rx_parity_err,
                          ifb.rx_frame_err});
    if (ifc.rx_valid)
      qc.push_back(frm_t'{{1'b0, ifc.rx_data},
                          ifc.rx_parity_err, ifc.rx_frame_err});
    if (rst_n) begin
      if (pv_a && ifa.rx_valid) viol++;
      if (pv_b && ifb.rx_valid) viol++;
      if (pv_c && ifc.rx_valid) viol++;
      if (!ifa.rx_valid && prev_a !== {ifa.rx_data,
          ifa.rx_parity_err, ifa.rx_frame_err}) viol++;
      if (!ifb.rx_valid && prev_b !== {ifb.rx_data,
          ifb.rx_parity_err, ifb.rx_frame_err}) viol++;
      if (!ifc.rx_valid && prev_c !== {ifc.rx_data,
          ifc.rx_parity_err, ifc.rx_frame_err}) viol++;
    end
    pv_a   = ifa.rx_valid;
    pv_b   = ifb.rx_valid;
    pv_c   = ifc.rx_valid;
    prev_a = {ifa.rx_data, ifa.rx_parity_err, ifa.rx_frame_err};
    prev_b = {ifb.rx_data, ifb.rx_parity_err, ifb.rx_frame_err};
    prev_c = {ifc.rx_data, ifc.rx_parity_err, ifc.rx_frame_err};
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected frame from the bits put on the line
  function automatic frm_t model(logic [7:0] d, int nb,
                                 int pmode, logic p, logic stopb);
    frm_t f;
    int   ones;
    f.d  = d & 8'((1 << nb) - 1);
    ones = $countones(f.d) + int'(p);
    if (pmode == 0)      f.pe = 1'b0;
    else if (pmode == 2) f.pe = (ones % 2) != 0;
    else                 f.pe = (ones % 2) == 0;
    f.fe = ~stopb;
    return f;
  endfunction

  task automatic set_line(int ln, logic v);
    case (ln)
      0: ifa.uart_rx = v;
      1: ifb.uart_rx = v;
      default: ifc.uart_rx = v;
    endcase
  endtask

  task automatic bitp(int ln, logic v, int n);
    set_line(ln, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(int ln, logic [7:0] d, int nb,
                            bit par, logic p, logic stopb,
                            int gap, int gl_bit);
    bitp(ln, 1'b0, BITCLK);
    for (int i = 0; i < nb; i++) begin
      if (i == gl_bit) begin
        bitp(ln, d[i], 32);
        bitp(ln, ~d[i], 4);
        bitp(ln, d[i], 28);
      end else begin
        bitp(ln, d[i], BITCLK);
      end
    end
    if (par) bitp(ln, p, BITCLK);
    bitp(ln, stopb, BITCLK);
    if (gap > 0) bitp(ln, 1'b1, BITCLK * gap);
  endtask

  function automatic int qsize(int ln);
    case (ln)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic pop(int ln, output frm_t f);
    case (ln)
      0: f = qa.pop_front();
      1: f = qb.pop_front();
      default: f = qc.pop_front();
    endcase
  endtask

  task automatic expect_n(int ln, frm_t e[$], string tag);
    frm_t g;
    chk({tag, "_count"}, qsize(ln), e.size());
    foreach (e[i]) begin
      if (qsize(ln) > 0) begin
        pop(ln, g);
        chk({tag, "_data"}, g.d, e[i].d);
        chk({tag, "_perr"}, g.pe, e[i].pe);
        chk({tag, "_ferr"}, g.fe, e[i].fe);
      end
    end
    while (qsize(ln) > 0) pop(ln, g);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic       rs;
    int         rg;
    checks   = 0;
    failures = 0;
    viol     = 0;
    rst_n    = 1'b0;
    ifa.uart_rx = 1'b1;
    ifb.uart_rx = 1'b1;
    ifc.uart_rx = 1'b1;
    #1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data", ifa.rx_data, 0);
    chk("rst_valid", ifa.rx_valid, 0);
    chk("rst_perr", ifa.rx_parity_err, 0);
    chk("rst_ferr", ifa.rx_frame_err, 0);
    chk("rst_busy", ifa.rx_busy, 0);
    chk("rst_busy_c", ifc.rx_busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bitp(0, 1'b1, 20);

    send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1, 1, -1);
    expect_n(0, '{model(8'hA5, 8, 0, 1'b0, 1'b1)}, "a5");
    chk("a5_busy_after", ifa.rx_busy, 0);

    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(3) != 0);
      rg = rs ? int'($urandom_range(2)) : int'($urandom_range(2, 1));
      send_frame(0, rd, 8, 0, 1'b0, rs, rg, -1);
      expect_n(0, '{model(rd, 8, 0, 1'b0, rs)}, "rnd8n1");
    end

    send_frame(0, 8'h7E, 8, 0, 1'b0, 1'b0, 1, -1);
    expect_n(0, '{model(8'h7E, 8, 0, 1'b0, 1'b0)}, "ferr");
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1, 1, -1);
    expect_n(0, '{model(8'h3C, 8, 0, 1'b0, 1'b1)}, "recov");

    bitp(0, 1'b0, BITCLK * 20);
    expect_n(0, '{model(8'h00, 8, 0, 1'b0, 1'b0)}, "break");
    bitp(0, 1'b1, BITCLK * 2);
    chk("break_quiet", qsize(0), 0);

    bitp(0, 1'b0, 12);
    chk("fstart_busy", ifa.rx_busy, 1);
    bitp(0, 1'b1, 60);
    chk("fstart_idle", ifa.rx_busy, 0);
    chk("fstart_nostrobe", qsize(0), 0);

    send_frame(0, 8'h00, 8, 0, 1'b0, 1'b1, 1, 2);
    expect_n(0, '{model(8'h00, 8, 0, 1'b0, 1'b1)}, "glitch00");
    for (int k = 0; k < 5; k++) begin
      rd = 8'($urandom);
      rg = int'($urandom_range(7));
      send_frame(0, rd, 8, 0, 1'b0, 1'b1, 1, rg);
      expect_n(0, '{model(rd, 8, 0, 1'b0, 1'b1)}, "glitch_rnd");
    end

    send_frame(1, 8'h03, 8, 1, 1'b1, 1'b1, 1, -1);
    expect_n(1, '{model(8'h03, 8, 2, 1'b1, 1'b1)}, "par_bad");
    send_frame(1, 8'h03, 8, 1, 1'b0, 1'b1, 1, -1);
    expect_n(1, '{model(8'h03, 8, 2, 1'b0, 1'b1)}, "par_ok");
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rg = int'($urandom_range(1));
      send_frame(1, rd, 8, 1, rp, 1'b1, rg, -1);
      expect_n(1, '{model(rd, 8, 2, rp, 1'b1)}, "par_rnd");
    end

    send_frame(2, 8'h55, 7, 0, 1'b0, 1'b1, 0, -1);
    send_frame(2, 8'h2A, 7, 0, 1'b0, 1'b1, 1, -1);
    expect_n(2, '{model(8'h55, 7, 0, 1'b0, 1'b1),
                  model(8'h2A, 7, 0, 1'b0, 1'b1)}, "b2b7");
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      rg = int'($urandom_range(1));
      send_frame(2, rd, 7, 0, 1'b0, 1'b1, rg, -1);
      expect_n(2, '{model(rd, 7, 0, 1'b0, 1'b1)}, "rnd7");
    end

    send_frame(0, 8'h5A, 8, 0, 1'b0, 1'b1, 1, -1);
    expect_n(0, '{model(8'h5A, 8, 0, 1'b0, 1'b1)}, "pre_rst");
    rd = 8'h81;
    bitp(0, 1'b0, BITCLK);
    for (int i = 0; i < 4; i++) bitp(0, rd[i], BITCLK);
    bitp(0, rd[4], 30);
    chk("mid_busy", ifa.rx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", ifa.rx_data, 0);
    chk("mrst_valid", ifa.rx_valid, 0);
    chk("mrst_busy", ifa.rx_busy, 0);
    chk("mrst_perr", ifa.rx_parity_err, 0);
    chk("mrst_ferr", ifa.rx_frame_err, 0);
    bitp(0, 1'b1, 10);
    rst_n = 1'b1;
    bitp(0, 1'b1, BITCLK * 2);
    chk("mrst_nostrobe", qsize(0), 0);
    send_frame(0, 8'h81, 8, 0, 1'b0, 1'b1, 1, -1);
    expect_n(0, '{model(8'h81, 8, 0, 1'b0, 1'b1)}, "post_rst");

    chk("strobe_shape", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
